// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB.
// Optional MC_CTRL_MEMWAIT_EN adds a mem_ready wait handshake in MEM.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MC_CTRL_MEMWAIT_EN
  input  logic       mem_ready,
`endif
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] NPCSel,
  output logic [2:0] ALUSrc,
  output logic [2:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       MemWrite,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t cur, nxt;

  logic is_r;
  logic i_j, i_jal, i_jr;
  logic i_addu, i_subu, i_ori, i_lui;
  logic i_lw, i_sw, i_beq, i_exec;
  logic mem_go;

  assign is_r   = (opcode == 6'b000000);
  assign i_j    = (opcode == 6'b000010);
  assign i_jal  = (opcode == 6'b000011);
  assign i_jr   = is_r && (funct == 6'b001000);
  assign i_addu = is_r && (funct == 6'b100001);
  assign i_subu = is_r && (funct == 6'b100011);
  assign i_ori  = (opcode == 6'b001101);
  assign i_lui  = (opcode == 6'b001111);
  assign i_lw   = (opcode == 6'b100011);
  assign i_sw   = (opcode == 6'b101011);
  assign i_beq  = (opcode == 6'b000100);
  assign i_exec = i_addu | i_subu | i_ori | i_lui
                | i_lw | i_sw | i_beq;

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  logic       ir_w, pc_w, rf_w, dm_w, ill;
  logic [1:0] npc, rdst, m2r;
  logic [2:0] src, aop;

  always_comb begin
    nxt  = FETCH;
    ir_w = 1'b0;
    pc_w = 1'b0;
    rf_w = 1'b0;
    dm_w = 1'b0;
    ill  = 1'b0;
    npc  = 2'd0;
    rdst = 2'd0;
    m2r  = 2'd0;
    src  = 3'd0;
    aop  = 3'd0;
    unique case (cur)
      FETCH: begin
        ir_w = 1'b1;
        pc_w = 1'b1;
        nxt  = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          i_j: begin
            pc_w = 1'b1;
            npc  = 2'd2;
          end
          i_jal: begin
            pc_w = 1'b1;
            npc  = 2'd2;
            rf_w = 1'b1;
            rdst = 2'd2;
            m2r  = 2'd2;
          end
          i_jr: begin
            pc_w = 1'b1;
            npc  = 2'd3;
          end
          i_exec: nxt = EXEC;
          default: ill = 1'b1;
        endcase
      end
      EXEC: begin
        unique case (1'b1)
          i_addu: nxt = WB;
          i_subu: begin
            aop = 3'd1;
            nxt = WB;
          end
          i_ori: begin
            src = 3'd2;
            aop = 3'd2;
            nxt = WB;
          end
          i_lui: begin
            src = 3'd3;
            nxt = WB;
          end
          i_lw, i_sw: begin
            src = 3'd1;
            nxt = MEM;
          end
          i_beq: begin
            aop  = 3'd1;
            npc  = 2'd1;
            pc_w = zero;
          end
          default: nxt = FETCH;
        endcase
      end
      MEM: begin
        // address operands stay on the ALU while memory is busy
        src  = 3'd1;
        dm_w = i_sw;
        if (!mem_go)   nxt = MEM;
        else if (i_lw) nxt = WB;
        else           nxt = FETCH;
      end
      WB: begin
        rf_w = 1'b1;
        rdst = is_r ? 2'd1 : 2'd0;
        m2r  = i_lw ? 2'd1 : 2'd0;
      end
      default: nxt = FETCH;
    endcase
  end

  // strobes are forced low while reset is held, in any state
  assign IRWrite  = ir_w & ~reset;
  assign PCWrite  = pc_w & ~reset;
  assign RegWrite = rf_w & ~reset;
  assign MemWrite = dm_w & ~reset;
  assign illegal  = ill  & ~reset;
  assign NPCSel   = npc;
  assign ALUSrc   = src;
  assign ALUOp    = aop;
  assign RegDst   = rdst;
  assign MemtoReg = m2r;
  assign state    = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against a per-instruction
// cycle-sequence model built from the instruction behaviour table.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, illegal;
  logic [1:0] NPCSel, RegDst, MemtoReg;
  logic [2:0] ALUSrc, ALUOp, state;
`ifdef MC_CTRL_MEMWAIT_EN
  logic       mem_ready;
`endif

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .funct(funct),
    .zero(zero),
`ifdef MC_CTRL_MEMWAIT_EN
    .mem_ready(mem_ready),
`endif
    .IRWrite(IRWrite),
    .PCWrite(PCWrite),
    .NPCSel(NPCSel),
    .ALUSrc(ALUSrc),
    .ALUOp(ALUOp),
    .RegWrite(RegWrite),
    .RegDst(RegDst),
    .MemtoReg(MemtoReg),
    .MemWrite(MemWrite),
    .illegal(illegal),
    .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] npc;
    logic [2:0] src;
    logic [2:0] aop;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       mw;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;

  function automatic exp_t observe();
    return {state, IRWrite, PCWrite, NPCSel, ALUSrc, ALUOp,
            RegWrite, RegDst, MemtoReg, MemWrite, illegal};
  endfunction

  function automatic string kind_of(input logic [5:0] op,
                                    input logic [5:0] fn);
    if (op == 6'h02) return "j";
    if (op == 6'h03) return "jal";
    if (op == 6'h00 && fn == 6'h08) return "jr";
    if (op == 6'h00 && fn == 6'h21) return "addu";
    if (op == 6'h00 && fn == 6'h23) return "subu";
    if (op == 6'h0d) return "ori";
    if (op == 6'h0f) return "lui";
    if (op == 6'h23) return "lw";
    if (op == 6'h2b) return "sw";
    if (op == 6'h04) return "beq";
    return "ill";
  endfunction

  // expected per-cycle outputs for one instruction, FETCH onward
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int hold);
    string k;
    exp_t  e;
    logic [2:0] s, a;
    k = kind_of(op, fn);
    q.delete();
    e = '0; e.st = 3'd0; e.irw = 1; e.pcw = 1;
    q.push_back(e);
    e = '0; e.st = 3'd1;
    if (k == "j" || k == "jal") begin
      e.pcw = 1; e.npc = 2;
    end
    if (k == "jal") begin
      e.rw = 1; e.rd = 2; e.m2r = 2;
    end
    if (k == "jr") begin
      e.pcw = 1; e.npc = 3;
    end
    if (k == "ill") e.ill = 1;
    q.push_back(e);
    if (k == "j" || k == "jal" || k == "jr" || k == "ill") return;
    s = 0; a = 0;
    if (k == "subu" || k == "beq") a = 1;
    if (k == "ori") begin s = 2; a = 2; end
    if (k == "lui") s = 3;
    if (k == "lw" || k == "sw") s = 1;
    e = '0; e.st = 3'd2; e.src = s; e.aop = a;
    if (k == "beq") begin
      e.npc = 1; e.pcw = z;
    end
    q.push_back(e);
    if (k == "beq") return;
    if (k == "lw" || k == "sw") begin
      for (int i = 0; i <= hold; i++) begin
        e = '0; e.st = 3'd3; e.src = s; e.aop = a;
        e.mw = (k == "sw");
        q.push_back(e);
      end
    end
    if (k == "sw") return;
    e = '0; e.st = 3'd4; e.rw = 1;
    e.rd = (op == 6'h00) ? 2'd1 : 2'd0;
    e.m2r = (k == "lw") ? 2'd1 : 2'd0;
    q.push_back(e);
  endtask

  // entered at posedge+1 in FETCH; stops after lim cycles
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input logic z,
                           input int hold, input int lim);
    exp_t e, o;
    int   n = 0;
    int   mi = 0;
    build(op, fn, z, hold);
    opcode = op; funct = fn; zero = z;
    while (q.size() > 0 && n < lim) begin
      e = q.pop_front();
`ifdef MC_CTRL_MEMWAIT_EN
      mem_ready = !(e.st == 3'd3 && mi < hold);
`endif
      if (e.st == 3'd3) mi++;
      @(negedge clk);
      o = observe();
      nchk++;
      if (o !== e) begin
        nfail++;
        $display("FAIL %s cyc %0d: got %h want %h", tag, n, o, e);
      end
      @(posedge clk); #1;
      n++;
    end
`ifdef MC_CTRL_MEMWAIT_EN
    mem_ready = 1'b1;
`endif
  endtask

  task automatic chk_strobes_low(input string tag, input logic [2:0] st);
    @(negedge clk);
    nchk++;
    if ({IRWrite, PCWrite, RegWrite, MemWrite, illegal} !== 5'b0 ||
        state !== st) begin
      nfail++;
      $display("FAIL %s: got st=%0d strb=%b want st=%0d strb=00000",
               tag, state,
               {IRWrite, PCWrite, RegWrite, MemWrite, illegal}, st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opcode = 6'h0; funct = 6'h21; zero = 1'b0;
`ifdef MC_CTRL_MEMWAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_strobes_low("reset_hold", 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_instr("addu", 6'h00, 6'h21, 1'b0, 0, 99);
    run_instr("lw", 6'h23, 6'h00, 1'b0, 0, 99);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 99);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0, 99);
    run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 99);
    run_instr("ill_3f", 6'h3f, 6'h00, 1'b0, 0, 99);
    run_instr("ill_rfn", 6'h00, 6'h20, 1'b0, 0, 99);
    run_instr("jr", 6'h00, 6'h08, 1'b0, 0, 99);
    run_instr("j", 6'h02, 6'h08, 1'b1, 0, 99);
    run_instr("sw", 6'h2b, 6'h00, 1'b0, 0, 99);
    run_instr("subu", 6'h00, 6'h23, 1'b1, 0, 99);
    run_instr("ori", 6'h0d, 6'h21, 1'b0, 0, 99);
    run_instr("lui", 6'h0f, 6'h00, 1'b0, 0, 99);
  endtask

  task automatic test_reset_mid();
    // abort sw in MEM, then every stage of lw
    run_instr("sw_pre", 6'h2b, 6'h00, 1'b0, 0, 3);
    reset = 1'b1;
    chk_strobes_low("rst_sw_mem", 3'd3);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("after_rst_sw", 6'h00, 6'h21, 1'b0, 0, 99);
    for (int k = 0; k < 5; k++) begin
      run_instr("lw_pre", 6'h23, 6'h00, 1'b0, 0, k);
      reset = 1'b1;
      chk_strobes_low("rst_lw_stage", k[2:0]);
      @(posedge clk); #1;
      reset = 1'b0;
    end
    run_instr("after_rst_lw", 6'h23, 6'h00, 1'b0, 0, 99);
  endtask

  task automatic test_random();
    logic [5:0] ops[12];
    logic [5:0] fns[12];
    logic [5:0] op, fn;
    int         sel;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h0d,
            6'h0f, 6'h23, 6'h2b, 6'h04, 6'h04, 6'h00};
    fns = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00,
            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 13);
      if (sel < 12) begin
        op = ops[sel];
        fn = (sel < 3) ? fns[sel] : 6'($urandom);
        if (sel == 11) fn = 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr("rand", op, fn, 1'($urandom), 0, 99);
    end
  endtask

`ifdef MC_CTRL_MEMWAIT_EN
  task automatic test_memwait();
    run_instr("sw_wait3", 6'h2b, 6'h00, 1'b0, 3, 99);
    run_instr("lw_wait2", 6'h23, 6'h00, 1'b0, 2, 99);
    for (int i = 0; i < 10; i++)
      run_instr("rand_wait", ($urandom_range(0, 1) != 0) ? 6'h23 : 6'h2b,
                6'h00, 1'b0, $urandom_range(0, 4), 99);
  endtask
`endif

  task automatic test_back_to_back();
    run_instr("b2b_j", 6'h02, 6'h00, 1'b0, 0, 99);
    run_instr("b2b_lw", 6'h23, 6'h00, 1'b0, 0, 99);
    run_instr("b2b_sw", 6'h2b, 6'h00, 1'b0, 0, 99);
    @(negedge clk);
    nchk++;
    if (state !== 3'd0) begin
      nfail++;
      $display("FAIL end_state: got %0d want 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
`ifdef MC_CTRL_MEMWAIT_EN
    test_memwait();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
